grid_frame_store: RTL
=====================

# grid_frame_store

Parametrised successor to the flat generation register of the cell-grid datapath. It collects the next generation of a COLS×ROWS cell grid row by row from the update engine through a valid/ready handshake into a shadow buffer. It then commits the complete frame atomically to the displayed grid register, so the display and neighbour logic never see a half-updated generation. It also counts committed generations and supports a synchronous clear.

## Interface
- COLS, 40, cells per row (row width in bits)
- ROWS, 25, rows per frame
- GEN_W, 16, width of generation counter
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  asynchronous, active-high reset
- load_start  input  1  request to begin collecting a new frame; sampled only in IDLE
- clear  input  1  zero the displayed grid and generation counter; sampled only in IDLE
- row_in  input  COLS  one row of next-generation cells; bit c = column c
- row_valid  input  1  row_in holds a valid row
- row_ready  output  1  block accepts a row this cycle
- arr  output  COLS*ROWS  displayed grid; row r occupies bits [r*COLS +: COLS]
- gen_count  output  GEN_W  number of committed frames since reset/clear
- busy  output  1  high in FILL and COMMIT
- done  output  1  one-cycle pulse coincident with the first cycle a new arr is visible
- changed  output  1  present only with GRID_CHANGED_EN (see Configuration)

## Operation
- States: IDLE, FILL, COMMIT. Row index counter has width $clog2(ROWS), minimum 1.
- IDLE:
  - clear=1 → arr and gen_count are set to 0 at the next edge; state stays IDLE.
  - Otherwise, load_start=1 → row index set to 0; go to FILL.
  - clear has priority over load_start when both are high.
- FILL:
  - row_ready=1.
  - On each edge with row_valid && row_ready, row_in is written to shadow row [index] and the index increments.
  - The handshake on row ROWS-1 moves the state to COMMIT. The index does not wrap past ROWS-1.
- COMMIT:
  - row_ready=0.
  - At the next edge: arr<=shadow, gen_count<=gen_count+1 (wraps modulo 2^GEN_W), done<=1, state→IDLE.
- Inputs ignored outside their state:
  - load_start and clear are ignored in FILL/COMMIT.
  - row_valid is ignored when row_ready=0 and no data is captured.
- The shadow buffer is not cleared between frames. Every row is overwritten before every commit, so stale contents are never visible.
- arr changes only on the COMMIT→IDLE edge, on a clear, or on reset.

## Timing
- Reset (async assert, deasserted synchronously by system):
  - State is IDLE.
  - arr, shadow, gen_count and row index are 0.
  - row_ready, busy and done are 0. changed is 0.
- Reset mid-FILL or mid-COMMIT aborts the frame. The partial shadow is discarded and arr returns to 0.
- load_start at edge t (IDLE) → row_ready=1 from cycle t+1.
- Minimum latency, load_start to new arr visible: ROWS+2 edges, with row_valid held high.
- Last row handshake at edge k → COMMIT during cycle k..k+1. arr, gen_count and done update at edge k+1.
- done is high exactly one cycle. busy falls in the same cycle done rises.
- load_start is accepted in the cycle done is high, because the state is IDLE. Back-to-back frames are therefore spaced ROWS+2 cycles apart.
- Stalls (row_valid=0) in FILL extend FILL indefinitely. There is no timeout.

## Configuration
- GRID_CHANGED_EN defined:
  - An extra output, changed, is compiled in.
  - It is registered at the COMMIT→IDLE edge as (shadow != arr), comparing the new frame against the old one.
  - It holds its value until the next commit or clear; clear sets it to 0.
  - It is used for still-life detection.
- GRID_CHANGED_EN undefined: the port and its comparator are absent. All other behaviour is identical.

## Test plan
- Reset value: assert rst mid-cycle with COLS=4, ROWS=3 → arr=0, gen_count=0, row_ready=0, busy=0 immediately, without waiting for a clock.
- Basic fill, COLS=4, ROWS=3:
  - Stimulus: load_start, then rows 4'hA, 4'h5, 4'hF with row_valid high.
  - Expected: arr=12'hF5A at edge 5 after load_start, gen_count=1, done high one cycle.
- Stalled fill:
  - Stimulus: same rows, with row_valid low for 2 cycles between rows 0 and 1.
  - Expected: commit delayed by 2 cycles, and arr stays at its old value until then.
- Ignored inputs:
  - load_start and clear pulsed during FILL → no effect.
  - row_valid in IDLE → no capture.
  - clear+load_start together in IDLE → arr=0, gen_count=0, state IDLE.
- Counter wrap: GEN_W=2, five frames → gen_count sequence 1,2,3,0,1.
- Mid-frame reset and the changed flag:
  - rst asserted after 1 of 3 rows → arr=0 and the next full frame commits cleanly.
  - With GRID_CHANGED_EN, committing an identical frame twice → changed=1, then 0.

Source files
------------

// File: rtl/grid_frame_store_if.sv
// rtl/grid_frame_store_if.sv - row stream handshake between the update engine and the frame store.
// The master drives row_in/row_valid; the frame store (slave) answers with row_ready.
interface grid_frame_store_if #(
    parameter int COLS = 40
) ();
    logic [COLS-1:0] row_in;
    logic            row_valid;
    logic            row_ready;

    modport master (output row_in, output row_valid, input row_ready);
    modport slave  (input row_in, input row_valid, output row_ready);
endinterface

// File: rtl/grid_frame_store.sv
// rtl/grid_frame_store.sv - double-buffered cell-grid frame store with atomic commit and generation count.
// Optional feature macro GRID_CHANGED_EN adds the registered 'changed' (still-life) output.
module grid_frame_store #(
    parameter int COLS  = 40,
    parameter int ROWS  = 25,
    parameter int GEN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   clear,
    grid_frame_store_if.slave      rows,
    output logic [COLS*ROWS-1:0]   arr,
    output logic [GEN_W-1:0]       gen_count,
    output logic                   busy,
`ifdef GRID_CHANGED_EN
    output logic                   changed,
`endif
    output logic                   done
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

    state_t                         state;
    logic [IDX_W-1:0]               idx;
    logic [ROWS-1:0][COLS-1:0]      shadow;

    // The displayed grid only moves on the COMMIT->IDLE edge, so readers never see a mixed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            shadow         <= '0;
            arr            <= '0;
            gen_count      <= '0;
            rows.row_ready <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef GRID_CHANGED_EN
            changed        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        arr       <= '0;
                        gen_count <= '0;
`ifdef GRID_CHANGED_EN
                        changed   <= 1'b0;
`endif
                    end else if (load_start) begin
                        idx            <= '0;
                        state          <= FILL;
                        rows.row_ready <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                FILL: begin
                    if (rows.row_valid && rows.row_ready) begin
                        shadow[idx] <= rows.row_in;
                        if (idx == LAST_IDX) begin
                            state          <= COMMIT;
                            rows.row_ready <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    arr       <= shadow;
                    gen_count <= gen_count + 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
`ifdef GRID_CHANGED_EN
                    changed   <= (shadow != arr);
`endif
                end
                default: begin
                    state          <= IDLE;
                    rows.row_ready <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end
endmodule
